// File: rtl/hex2ascii_pkg.sv
// rtl/hex2ascii_pkg.sv - ASCII constants and FSM state encoding for hex2ascii_stream
package hex2ascii_pkg;

  localparam logic [7:0] ASCII_DIGIT0  = 8'h30;
  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

endpackage

// File: rtl/nibble2ascii.sv
// rtl/nibble2ascii.sv - combinational nibble to hex ASCII character
module nibble2ascii
  import hex2ascii_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       lower_i,
  output logic [7:0] char_o
);

  always_comb begin
    if (nibble_i < 4'd10) begin
      char_o = ASCII_DIGIT0 + {4'h0, nibble_i};
    end else if (lower_i) begin
      char_o = ASCII_LOWER_A + {4'h0, nibble_i} - 8'd10;
    end else begin
      char_o = ASCII_UPPER_A + {4'h0, nibble_i} - 8'd10;
    end
  end

endmodule

// File: rtl/hex2ascii_stream.sv
// rtl/hex2ascii_stream.sv - word to hex ASCII character stream, MS nibble first
// Optional leading-zero suppression with HEX2ASCII_ZSUP_EN.
module hex2ascii_stream
  import hex2ascii_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_lower,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              out_last
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d, load_idx;
  logic              lower_q, lower_d;
  logic              accept, step, last;
  logic [3:0]        nibble;
  logic [7:0]        char_w;

  assign last      = (state_q == ST_EMIT) && (idx_q == '0);
  // A new word may land in the same cycle the final character is taken.
  assign in_ready  = !rst && ((state_q == ST_IDLE) || (last && out_ready));
  assign accept    = in_valid && in_ready;
  assign step      = (state_q == ST_EMIT) && out_ready;
  assign out_valid = (state_q == ST_EMIT);
  assign out_last  = last;

  assign nibble = 4'(word_q >> {idx_q, 2'b00});

  nibble2ascii u_nibble2ascii (
    .nibble_i (nibble),
    .lower_i  (lower_q),
    .char_o   (char_w)
  );

  assign out_char = out_valid ? char_w : 8'h00;

`ifdef HEX2ASCII_ZSUP_EN
  // Start at the most significant nonzero nibble; an all-zero word yields idx 0.
  always_comb begin
    load_idx = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (in_data[4*i +: 4] != 4'h0) load_idx = IDX_W'(i);
    end
  end
`else
  assign load_idx = IDX_W'(NIBBLES - 1);
`endif

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    lower_d = lower_q;
    if (accept) begin
      state_d = ST_EMIT;
      word_d  = in_data;
      lower_d = in_lower;
      idx_d   = load_idx;
    end else if (step) begin
      if (idx_q != '0) begin
        idx_d = idx_q - IDX_W'(1);
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      lower_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      lower_q <= lower_d;
    end
  end

endmodule

// File: tb/tb_hex2ascii_stream.sv
// tb/tb_hex2ascii_stream.sv - randomized self-checking bench for hex2ascii_stream
module tb_hex2ascii_stream;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_lower;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_char;
  logic        out_last;

  hex2ascii_stream #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_lower  (in_lower),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_last  (out_last)
  );

  typedef struct {
    logic [7:0] c;
    logic       last;
  } exp_t;

  exp_t        pending[$];
  logic [31:0] stim_word[$];
  logic        stim_lower[$];

  int n_vec = 0;
  int n_err = 0;
  int out_hs_cnt = 0;
  int hold_cnt = 0;
  bit ready_rand = 0;
  bit gap_rand = 0;
  bit took_in = 0;
  bit was_rst = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected text straight from the printed hex form of the word.
  function automatic void push_word(input logic [31:0] w, input logic lo);
    string s;
    exp_t  e;
`ifdef HEX2ASCII_ZSUP_EN
    s = $sformatf("%0h", w);
`else
    s = $sformatf("%h", w);
`endif
    if (!lo) s = s.toupper();
    for (int i = 0; i < s.len(); i++) begin
      e.c    = s[i];
      e.last = (i == s.len() - 1);
      pending.push_back(e);
    end
  endfunction

  // Monitor and reference model, sampled away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check_eq("in_ready_in_rst", {31'b0, in_ready}, 32'd0);
        pending.delete();
        took_in = 0;
        was_rst = 1;
      end else begin
        check_eq("out_valid", {31'b0, out_valid}, {31'b0, pending.size() != 0});
        check_eq("in_ready", {31'b0, in_ready},
                 {31'b0, (pending.size() == 0) || (pending.size() == 1 && out_ready)});
        if (pending.size() != 0) begin
          check_eq("out_char", {24'b0, out_char}, {24'b0, pending[0].c});
          check_eq("out_last", {31'b0, out_last}, {31'b0, pending[0].last});
        end else begin
          check_eq("out_last_idle", {31'b0, out_last}, 32'd0);
        end
        if (was_rst) check_eq("out_char_after_rst", {24'b0, out_char}, 32'd0);
        was_rst = 0;
        took_in = in_valid && in_ready;
        if (out_valid && out_ready && pending.size() != 0) begin
          void'(pending.pop_front());
          out_hs_cnt++;
        end
        if (took_in) push_word(in_data, in_lower);
      end
    end
  end

  // Driver: offers queued words and shapes out_ready.
  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    in_lower  = 1'b0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (took_in && stim_word.size() != 0) begin
        void'(stim_word.pop_front());
        void'(stim_lower.pop_front());
        took_in = 0;
      end
      if (stim_word.size() != 0 && !(gap_rand && $urandom_range(0, 3) == 0)) begin
        in_valid = 1'b1;
        in_data  = stim_word[0];
        in_lower = stim_lower[0];
      end else begin
        in_valid = 1'b0;
        in_data  = $urandom;
        in_lower = 1'($urandom);
      end
      if (hold_cnt > 0) begin
        out_ready = 1'b0;
        hold_cnt--;
      end else begin
        out_ready = ready_rand ? 1'($urandom) : 1'b1;
      end
    end
  end

  task automatic send(input logic [31:0] w, input logic lo);
    stim_word.push_back(w);
    stim_lower.push_back(lo);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((stim_word.size() != 0 || pending.size() != 0 || in_valid) && n < 2000);
    if (n >= 2000) check_eq("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_chars(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (out_hs_cnt < target && n < 2000);
    if (n >= 2000) check_eq("char_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    send(32'h1234ABCD, 1'b0);
    wait_idle();
    send(32'hDEADBEEF, 1'b1);
    wait_idle();

    send(32'h1234ABCD, 1'b0);
    wait_chars(out_hs_cnt + 1);
    hold_cnt = 3;
    wait_idle();

    send(32'h00000001, 1'b0);
    send(32'hFFFFFFFF, 1'b0);
    wait_idle();

    send(32'h1234ABCD, 1'b0);
    wait_chars(out_hs_cnt + 3);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    send(32'h00000000, 1'b0);
    wait_idle();

    send(32'h000000A5, 1'b0);
    send(32'h00000000, 1'b1);
    send(32'h80000000, 1'b0);
    wait_idle();

    ready_rand = 1;
    gap_rand   = 1;
    for (int i = 0; i < 60; i++) begin
      send($urandom >> (4 * $urandom_range(0, 8)), 1'($urandom));
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
